pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for a five-stage in-order pipeline.
// The controller freezes every stage while either memory is still busy. It
// flushes the younger stages when a branch in MEM turns out mispredicted. It
// inserts one bubble into EX when an instruction in ID needs the result of a
// load that is still in EX. It also counts memory-busy cycles and raises a
// sticky hang flag if memory stays busy for too long.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   imem_read, imem_resp       instruction fetch request / completion
//   dmem_req, dmem_resp        data access request / completion
//   mem_mispredict             branch in MEM resolved mispredicted
//   id_ex_mem_read, id_ex_dr   load-in-EX flag and its destination register
//   if_id_sr1/sr2, uses_sr1/2  source registers read by the instruction in ID
//   ex_load_cc                 instruction in EX writes condition codes
//   *_load                     pipeline register load enables
//   *_reset                    pipeline register synchronous clears (bubbles)
//   stall_cycles               saturating count of memory-busy cycles
//   stall_timeout              sticky flag: memory busy for TIMEOUT cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             mem_mispredict,
    input  logic             id_ex_mem_read,
    input  logic [2:0]       id_ex_dr,
    input  logic [2:0]       if_id_sr1,
    input  logic [2:0]       if_id_sr2,
    input  logic             if_id_uses_sr1,
    input  logic             if_id_uses_sr2,
    input  logic             ex_load_cc,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             ex_mem_load_cc,
    output logic             mem_wb_load,
    output logic             if_id_reset,
    output logic             id_ex_reset,
    output logic             ex_mem_reset,
    output logic             mem_wb_reset,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HUNG  = 2'd2
    } state_t;

    // Run length that, when seen with memory still busy, means this is the
    // TIMEOUT-th consecutive busy cycle.
    localparam logic [7:0] RUN_LEN_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       run_len;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_busy;
    logic             load_use;

    // A memory is busy when it has a request outstanding that it does not
    // complete this cycle. A load-use hazard exists when ID reads the
    // register that the load in EX has not yet produced.
    always_comb begin
        mem_busy = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
        load_use = id_ex_mem_read &
                   ((if_id_uses_sr1 & (if_id_sr1 == id_ex_dr)) |
                    (if_id_uses_sr2 & (if_id_sr2 == id_ex_dr)));
    end

    // Stall watchdog next-state logic. HUNG can only be left through reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mem_busy)
                    state_next = STALL;
            end
            STALL: begin
                if (!mem_busy)
                    state_next = RUN;
                else if (run_len == RUN_LEN_LAST)
                    state_next = HUNG;
            end
            HUNG: begin
                state_next = HUNG;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // Consecutive busy-cycle counter. It saturates so that a long hang
    // cannot wrap it back into a small value.
    always_ff @(posedge clk) begin
        if (reset)
            run_len <= 8'd0;
        else if (mem_busy) begin
            if (run_len != 8'hFF)
                run_len <= run_len + 8'd1;
        end
        else
            run_len <= 8'd0;
    end

    // Total busy-cycle counter. It sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (mem_busy && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign stall_cycles  = stall_cnt;
    assign stall_timeout = (state == HUNG);

    // Pipeline control, highest priority first: reset, memory freeze,
    // mispredict flush, load-use bubble, then normal flow. A freeze holds
    // every register, so a pending flush or bubble is still there when the
    // freeze ends and is handled then.
    always_comb begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        if_id_reset  = 1'b0;
        id_ex_reset  = 1'b0;
        ex_mem_reset = 1'b0;
        mem_wb_reset = 1'b0;
        if (reset) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            mem_wb_load  = 1'b0;
            if_id_reset  = 1'b1;
            id_ex_reset  = 1'b1;
            ex_mem_reset = 1'b1;
            mem_wb_reset = 1'b1;
        end
        else if (mem_busy) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            mem_wb_load  = 1'b0;
        end
        else if (mem_mispredict) begin
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            if_id_reset  = 1'b1;
            id_ex_reset  = 1'b1;
            ex_mem_reset = 1'b1;
        end
        else if (load_use) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            id_ex_reset  = 1'b1;
        end
    end

    // Condition codes advance only together with the EX/MEM register.
    assign ex_mem_load_cc = ex_mem_load & ex_load_cc;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. Directed scenarios come first,
// then randomized traffic. Every cycle is compared against a behavioural model
// built from the controller's rules: a per-situation control table, plain
// integer counters for busy cycles, and a sticky hang flag.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 255;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             mem_mispredict;
    logic             id_ex_mem_read;
    logic [2:0]       id_ex_dr;
    logic [2:0]       if_id_sr1;
    logic [2:0]       if_id_sr2;
    logic             if_id_uses_sr1;
    logic             if_id_uses_sr2;
    logic             ex_load_cc;
    logic             pc_load;
    logic             if_id_load;
    logic             id_ex_load;
    logic             ex_mem_load;
    logic             ex_mem_load_cc;
    logic             mem_wb_load;
    logic             if_id_reset;
    logic             id_ex_reset;
    logic             ex_mem_reset;
    logic             mem_wb_reset;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int model_busy_total = 0;
    int model_busy_run   = 0;
    bit model_hung       = 1'b0;

    pipeline_hazard_ctrl #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_read     (imem_read),
        .imem_resp     (imem_resp),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .mem_mispredict(mem_mispredict),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_dr      (id_ex_dr),
        .if_id_sr1     (if_id_sr1),
        .if_id_sr2     (if_id_sr2),
        .if_id_uses_sr1(if_id_uses_sr1),
        .if_id_uses_sr2(if_id_uses_sr2),
        .ex_load_cc    (ex_load_cc),
        .pc_load       (pc_load),
        .if_id_load    (if_id_load),
        .id_ex_load    (id_ex_load),
        .ex_mem_load   (ex_mem_load),
        .ex_mem_load_cc(ex_mem_load_cc),
        .mem_wb_load   (mem_wb_load),
        .if_id_reset   (if_id_reset),
        .id_ex_reset   (id_ex_reset),
        .ex_mem_reset  (ex_mem_reset),
        .mem_wb_reset  (mem_wb_reset),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Expected control vector for the current inputs, ordered
    // {pc, if_id, id_ex, ex_mem, ex_mem_cc, mem_wb loads, if_id, id_ex,
    // ex_mem, mem_wb resets}.
    function automatic logic [9:0] expectedControl();
        bit busy;
        bit hazard;
        busy   = (imem_read && !imem_resp) || (dmem_req && !dmem_resp);
        hazard = id_ex_mem_read &&
                 ((if_id_uses_sr1 && if_id_sr1 == id_ex_dr) ||
                  (if_id_uses_sr2 && if_id_sr2 == id_ex_dr));
        if (reset)          return 10'b000000_1111;
        if (busy)           return 10'b000000_0000;
        if (mem_mispredict) return 10'b100001_1110;
        if (hazard)         return {5'b00010, 1'b1, 4'b0100} | {4'b0, ex_load_cc, 5'b0};
        return {4'b1111, ex_load_cc, 1'b1, 4'b0000};
    endfunction

    // Advance the model across one clock edge using the inputs seen there.
    task automatic modelEdge();
        bit busy;
        busy = (imem_read && !imem_resp) || (dmem_req && !dmem_resp);
        if (reset) begin
            model_busy_total = 0;
            model_busy_run   = 0;
            model_hung       = 1'b0;
        end
        else if (busy) begin
            if (model_busy_total < CNT_MAX)
                model_busy_total++;
            model_busy_run++;
            if (model_busy_run >= TIMEOUT)
                model_hung = 1'b1;
        end
        else
            model_busy_run = 0;
    endtask

    // Run one cycle with the currently driven inputs: check every output
    // mid-cycle, then step the model and the DUT through the next edge.
    task automatic applyStimulus(input string tag);
        logic [9:0] observed;
        logic [3:0] overlap;
        @(negedge clk);
        observed = {pc_load, if_id_load, id_ex_load, ex_mem_load, ex_mem_load_cc,
                    mem_wb_load, if_id_reset, id_ex_reset, ex_mem_reset, mem_wb_reset};
        overlap  = {if_id_load & if_id_reset, id_ex_load & id_ex_reset,
                    ex_mem_load & ex_mem_reset, mem_wb_load & mem_wb_reset};
        checkOutput({tag, ":ctrl"}, 32'(observed), 32'(expectedControl()));
        checkOutput({tag, ":overlap"}, 32'(overlap), 32'd0);
        checkOutput({tag, ":stall_cycles"}, 32'(stall_cycles), 32'(model_busy_total));
        checkOutput({tag, ":stall_timeout"}, 32'(stall_timeout), 32'(model_hung));
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic setIdle();
        reset          = 1'b0;
        imem_read      = 1'b0;
        imem_resp      = 1'b0;
        dmem_req       = 1'b0;
        dmem_resp      = 1'b0;
        mem_mispredict = 1'b0;
        id_ex_mem_read = 1'b0;
        id_ex_dr       = 3'd0;
        if_id_sr1      = 3'd0;
        if_id_sr2      = 3'd0;
        if_id_uses_sr1 = 1'b0;
        if_id_uses_sr2 = 1'b0;
        ex_load_cc     = 1'b0;
    endtask

    // Set up the load-use pattern: load to r3 in EX, ID reads r3 on sr2.
    task automatic setLoadUse();
        id_ex_mem_read = 1'b1;
        id_ex_dr       = 3'd3;
        if_id_sr1      = 3'd5;
        if_id_sr2      = 3'd3;
        if_id_uses_sr1 = 1'b1;
        if_id_uses_sr2 = 1'b1;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: full clear, counters zero.
        applyStimulus("reset");
        reset = 1'b0;

        // Idle flow with no hazards.
        for (int i = 0; i < 3; i++)
            applyStimulus("idle");
        checkOutput("idle_count", 32'(stall_cycles), 32'd0);

        // One load-use bubble, with condition codes passed along.
        setLoadUse();
        ex_load_cc = 1'b1;
        applyStimulus("load_use");
        // Same hazard under a data-memory freeze: cc load must drop.
        dmem_req = 1'b1;
        applyStimulus("load_use_frozen");
        setIdle();

        // Data memory busy for four cycles, then completes.
        reset = 1'b1;
        applyStimulus("reset2");
        reset    = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus("dmem_wait");
        dmem_resp = 1'b1;
        applyStimulus("dmem_done");
        checkOutput("dmem_count", 32'(stall_cycles), 32'd4);
        setIdle();

        // Mispredict deferred behind a two-cycle fetch stall.
        mem_mispredict = 1'b1;
        imem_read      = 1'b1;
        for (int i = 0; i < 2; i++)
            applyStimulus("mispred_frozen");
        imem_resp = 1'b1;
        applyStimulus("mispred_flush");
        setIdle();

        // Long data stall trips the hang flag, which stays set after the
        // access completes and clears only on reset. The busy count also
        // saturates at the top of its range here.
        reset = 1'b1;
        applyStimulus("reset3");
        reset    = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < TIMEOUT; i++)
            applyStimulus("hang_wait");
        checkOutput("hang_set", 32'(stall_timeout), 32'd1);
        for (int i = 0; i < 2; i++)
            applyStimulus("hang_saturate");
        dmem_resp = 1'b1;
        applyStimulus("hang_sticky");
        checkOutput("hang_still_set", 32'(stall_timeout), 32'd1);
        setLoadUse();
        applyStimulus("hang_load_use");
        setIdle();
        reset = 1'b1;
        applyStimulus("hang_reset");
        checkOutput("hang_cleared", 32'(stall_timeout), 32'd0);
        reset = 1'b0;

        // Randomized traffic, with registers drawn from a small range so that
        // load-use matches happen often.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 499) == 0);
            imem_read      = $urandom_range(0, 1);
            imem_resp      = ($urandom_range(0, 3) != 0);
            dmem_req       = $urandom_range(0, 1);
            dmem_resp      = ($urandom_range(0, 2) != 0);
            mem_mispredict = ($urandom_range(0, 5) == 0);
            id_ex_mem_read = $urandom_range(0, 1);
            id_ex_dr       = 3'($urandom_range(0, 3));
            if_id_sr1      = 3'($urandom_range(0, 3));
            if_id_sr2      = 3'($urandom_range(0, 3));
            if_id_uses_sr1 = $urandom_range(0, 1);
            if_id_uses_sr2 = $urandom_range(0, 1);
            ex_load_cc     = $urandom_range(0, 1);
            applyStimulus("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
